nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, 8..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have ports a, b  input  WIDTH each  operands, unsigned.
REQ-007 SHALL have port cin  input  1  carry-in to the least-significant nibble.
REQ-008 SHALL have port out_valid  output  1  result held on sum/cout.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports sum  output  WIDTH and cout  output  1  result and final carry.
REQ-011 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 In IDLE: in_ready=1 and out_valid=0; in_valid=1 on an edge SHALL capture a, b and cin into registers, clear slice counter to 0, and move to CALC.
REQ-014 In CALC: each cycle SHALL add nibble[k] of captured a and b plus the carry register through one 4-bit carry-select adder, write the 4-bit result to sum bits [4k+3:4k], load the carry register with the adder carry-out, and increment k.
REQ-015 When k = WIDTH/4-1 is processed, the FSM SHALL move to DONE and load cout with that slice's carry-out.
REQ-016 Latency: handshake accepted on edge T SHALL give out_valid=1 after edge T+WIDTH/4. For WIDTH=16, that is 4 edges.
REQ-017 In DONE: out_valid=1, and sum and cout SHALL be stable. out_valid&&out_ready on an edge SHALL return the FSM to IDLE.
REQ-018 in_ready SHALL be 0 in CALC and DONE. in_valid in those states SHALL be ignored and SHALL NOT corrupt the captured operands.
REQ-019 There is no bypass: in_ready SHALL rise one cycle after the output handshake.
REQ-020 Arithmetic is modulo 2^WIDTH. cout SHALL equal bit WIDTH of a+b+cin.
REQ-021 sum SHALL hold the previous result until overwritten slice-by-slice in the next CALC. Consumers SHALL sample it only while out_valid=1.
REQ-022 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for clk, force the following values: state IDLE, slice counter 0, carry register 0, sum 0, cout 0, out_valid 0, busy 0, in_ready 1 combinationally from IDLE.
REQ-024 Reset asserted during CALC or DONE SHALL discard the operation. After release, the first accepted operand set SHALL compute correctly.
REQ-025 No output SHALL depend on uninitialised state after reset release.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, CALC, DONE) and the constant NIBBLE=4.
REQ-027 SHALL instantiate exactly one sub-module, carry_select_adder: 4-bit a and b, cin, 4-bit sum, cout. It is the existing combinational block, unmodified.
REQ-028 The slice counter SHALL be $clog2(WIDTH/4) bits wide, minimum 1.

Verification
REQ-029 a=0x0003, b=0x0004, cin=0 -> 4 edges later out_valid=1, sum=0x0007, cout=0.
REQ-030 a=0x0BBB, b=0x0333, cin=1 -> sum=0x0EEF, cout=0. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; checks full carry ripple across all slices.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0, new in_valid ignored. Then release -> IDLE next edge.
REQ-032 Drive rst_n=0 during CALC at k=2 -> outputs reach reset values before the next edge. After release, 0x1234+0x4321 with cin=0 -> 0x5555, cout=0.
REQ-033 Back-to-back: keep in_valid=1 with out_ready=1 -> one result per WIDTH/4+2 cycles, each result matching a reference model.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-select adder: both carry-in cases are precomputed, cin picks one.
module carry_select_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_s0;
  logic [4:0] w_s1;

  assign w_s0        = {1'b0, a} + {1'b0, b};
  assign w_s1        = {1'b0, a} + {1'b0, b} + 5'd1;
  assign {cout, sum} = cin ? w_s1 : w_s0;

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit
// carry-select adder, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSL = WIDTH / NIBBLE;
  localparam int KW  = (NSL > 2) ? $clog2(NSL) : 1;

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic             r_cout;

  logic [KW+1:0]    w_base;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;

  // Bit offset of the current slice (k * 4).
  assign w_base = {r_k, 2'b00};
  assign w_last = (r_k == KW'(NSL - 1));

  carry_select_adder u_csa (
    .a    (r_a[w_base +: NIBBLE]),
    .b    (r_b[w_base +: NIBBLE]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: capture in IDLE, walk slices in CALC, hold result in DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = CALC;
      CALC:    if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture and slice-by-slice accumulation of the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_k     <= '0;
        end
        CALC: begin
          r_sum[w_base +: NIBBLE] <= w_slice_sum;
          r_carry                 <= w_slice_cout;
          r_k                     <= r_k + 1'b1;
          if (w_last) r_cout <= w_slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed vectors, backpressure, mid-op reset and a
// randomized back-to-back stream checked against plain a+b+cin arithmetic.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NSL = W / 4;

  logic         gclk = 1'b0;
  logic         grst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [W-1:0] a, b, sum;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 gclk = ~gclk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (gclk),
    .rst_n     (grst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: full-width sum with the carry in bit W.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // One operation: offer, measure latency, check result, optional stall, drain.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input int hold);
    logic [W:0] exp;
    int cyc;
    exp = ref_add(xa, xb, xc);
    @(negedge gclk);
    chk("in_ready_idle", in_ready, 1);
    a = xa; b = xb; cin = xc; in_valid = 1; out_ready = 0;
    @(negedge gclk);
    in_valid = 0;
    a = ~xa; b = ~xb; cin = ~xc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge gclk);
      cyc++;
    end
    chk("latency", cyc, NSL);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge gclk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_sum", sum, exp[W-1:0]);
      chk("hold_cout", cout, exp[W]);
    end
    in_valid = 0; out_ready = 1;
    @(negedge gclk);
    out_ready = 0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
  endtask

  initial begin
    logic [W:0]   q[$];
    logic [W:0]   exp;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           last, n_out;

    grst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    repeat (2) @(negedge gclk);
    grst_n = 1;

    run_op(16'h0003, 16'h0004, 1'b0, 0);
    run_op(16'h0BBB, 16'h0333, 1'b1, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_op(16'hA5C3, 16'h7E19, 1'b1, 5);

    // Reset in the middle of CALC with slice 2 pending.
    @(negedge gclk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1; in_valid = 1;
    @(negedge gclk);
    in_valid = 0;
    repeat (2) @(negedge gclk);
    chk("mid_busy", busy, 1);
    grst_n = 0;
    #1;
    chk("mrst_sum", sum, 0);
    chk("mrst_cout", cout, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge gclk);
    grst_n = 1;
    run_op(16'h1234, 16'h4321, 1'b0, 0);

    // Back-to-back random stream with both sides always willing.
    @(negedge gclk);
    in_valid = 1; out_ready = 1;
    last = -1; n_out = 0;
    for (int t = 0; t < 80; t++) begin
      if (out_valid) begin
        chk("b2b_have_ref", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp = q.pop_front();
          chk("b2b_sum", sum, exp[W-1:0]);
          chk("b2b_cout", cout, exp[W]);
        end
        if (last >= 0) chk("b2b_period", t - last, NSL + 2);
        last = t;
        n_out++;
      end
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (t % 7 == 0) ra = '1;
      a = ra; b = rb; cin = rc;
      if (in_ready) q.push_back(ref_add(ra, rb, rc));
      @(negedge gclk);
    end
    chk("b2b_count_min", n_out >= 10, 1);
    in_valid = 0; out_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
